// File: rtl/config_shift_reg_responder.sv
// Chip-side model of the configuration shift register and load latch.
// Pins are sampled in the ACLK domain; ConfigOut loops back to the FPGA.
module config_shift_reg_responder #(
  parameter  int CONFIG_REG_WIDTH = 5164,
  localparam int CW = $clog2(CONFIG_REG_WIDTH + 1)
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic                        ConfigClk,
  input  logic                        ConfigIn,
  input  logic                        ConfigLoad,
  input  logic                        Reset_not,
  input  logic                        SuperpixSel,
  output logic                        ConfigOut,
  output logic [CONFIG_REG_WIDTH-1:0] ParallelOut,
  output logic                        SuperpixSel_q,
  output logic                        load_done,
  output logic                        length_err,
  output logic [CW-1:0]               shift_count
);

  localparam int W = CONFIG_REG_WIDTH;

  localparam int I_CLK  = 0;
  localparam int I_DIN  = 1;
  localparam int I_LOAD = 2;
  localparam int I_RSTN = 3;
  localparam int I_SEL  = 4;

  logic [4:0] pins;
  logic [4:0] s1;
  logic [4:0] s2;
  logic [4:0] s3;

  logic [W-1:0]  sr;
  logic [W-1:0]  sr_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          clk_rise;
  logic          load_rise;
  logic          chip_run;
  logic          unused_s3;

  assign pins = {SuperpixSel, Reset_not, ConfigLoad, ConfigIn, ConfigClk};

  // All pins share one depth so data stays aligned with its clock edge.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign unused_s3 = ^{s3[I_DIN], s3[I_RSTN], s3[I_SEL]};

  assign clk_rise  = s2[I_CLK] & ~s3[I_CLK];
  assign load_rise = s2[I_LOAD] & ~s3[I_LOAD];
  assign chip_run  = s2[I_RSTN];

  always_comb begin
    sr_nxt  = sr;
    cnt_nxt = shift_count;
    if (clk_rise) begin
      sr_nxt = {sr[W-2:0], s2[I_DIN]};
      if (shift_count != '1)
        cnt_nxt = shift_count + CW'(1);
    end
  end

  // Load sees the post-shift image, so a coincident clock edge is included.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      sr            <= '0;
      ParallelOut   <= '0;
      SuperpixSel_q <= 1'b0;
      load_done     <= 1'b0;
      length_err    <= 1'b0;
      shift_count   <= '0;
    end else if (!chip_run) begin
      sr            <= '0;
      ParallelOut   <= '0;
      SuperpixSel_q <= 1'b0;
      load_done     <= 1'b0;
      length_err    <= 1'b0;
      shift_count   <= '0;
    end else begin
      sr        <= sr_nxt;
      load_done <= load_rise;
      if (load_rise) begin
        ParallelOut   <= sr_nxt;
        SuperpixSel_q <= s2[I_SEL];
        length_err    <= (cnt_nxt != CW'(W));
        shift_count   <= '0;
      end else begin
        shift_count <= cnt_nxt;
      end
    end
  end

  assign ConfigOut = sr[W-1];

endmodule

// File: tb/tb_config_shift_reg_responder.sv
// Scoreboard bench for config_shift_reg_responder at an 8-bit width.
// Loads push expectations; a monitor pops them on each load_done.
module tb_config_shift_reg_responder;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cclk;
  logic          cin;
  logic          cload;
  logic          rstn;
  logic          sel;
  logic          co;
  logic [W-1:0]  po;
  logic          selq;
  logic          ld;
  logic          lerr;
  logic [CW-1:0] cnt;

  config_shift_reg_responder #(.CONFIG_REG_WIDTH(W)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .ConfigClk    (cclk),
    .ConfigIn     (cin),
    .ConfigLoad   (cload),
    .Reset_not    (rstn),
    .SuperpixSel  (sel),
    .ConfigOut    (co),
    .ParallelOut  (po),
    .SuperpixSel_q(selq),
    .load_done    (ld),
    .length_err   (lerr),
    .shift_count  (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] po;
    logic         err;
    logic         sel;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_sr;
  int           m_cnt;
  int           passed = 0;
  int           total  = 0;
  logic         prev_ld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ld = 1'b0;
    end else begin
      if (ld) begin
        chk("load_done_single", 32'(prev_ld), 32'd0);
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_load_done: got 1 expected 0");
        end else begin
          e = q.pop_front();
          chk("parallel_out", 32'(po), 32'(e.po));
          chk("length_err", 32'(lerr), 32'(e.err));
          chk("superpix_sel_q", 32'(selq), 32'(e.sel));
        end
      end
      prev_ld = ld;
    end
  end

  task automatic push_exp();
    exp_t e;
    e.po  = m_sr;
    e.err = (m_cnt != W);
    e.sel = sel;
    q.push_back(e);
    m_cnt = 0;
  endtask

  task automatic shift_bit(input logic b, input logic with_load);
    logic old;
    @(posedge clk); #1 cin = b;
    repeat (4) @(posedge clk);
    #1;
    old  = m_sr[W-1];
    m_sr = {m_sr[W-2:0], b};
    if (m_cnt < 15) m_cnt++;
    if (with_load) begin
      push_exp();
      cload = 1'b1;
    end
    cclk = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("cfgout_hold1", 32'(co), 32'(old));
    @(posedge clk); @(negedge clk);
    chk("cfgout_hold2", 32'(co), 32'(old));
    @(posedge clk); @(negedge clk);
    chk("cfgout_update", 32'(co), 32'(m_sr[W-1]));
    repeat (7) @(posedge clk);
    #1 cclk = 1'b0;
    cload = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n,
                            input logic last_load);
    for (int i = n - 1; i >= 0; i--)
      shift_bit(v[i], last_load && (i == 0));
  endtask

  task automatic do_load();
    @(posedge clk); #1;
    push_exp();
    cload = 1'b1;
    repeat (5) @(posedge clk);
    #1 cload = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("count_cleared", 32'(cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cclk = 1'b0; cin = 1'b0; cload = 1'b0;
    rstn = 1'b1; sel = 1'b0;
    m_sr = '0; m_cnt = 0;
    #1;
    chk("rst_cfgout", 32'(co), 32'd0);
    chk("rst_parallel", 32'(po), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_load_done", 32'(ld), 32'd0);
    chk("rst_len_err", 32'(lerr), 32'd0);
    chk("rst_sel_q", 32'(selq), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // 0xA5 MSB-first, then a clean load with SuperpixSel set
    sel = 1'b1;
    shift_bits(32'hA5, 8, 1'b0);
    @(negedge clk);
    chk("count_8", 32'(cnt), 32'd8);
    do_load();

    // async reset in the middle of a shift
    shift_bits(32'h7, 3, 1'b0);
    @(negedge clk);
    chk("count_3", 32'(cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_cfgout", 32'(co), 32'd0);
    chk("arst_parallel", 32'(po), 32'd0);
    chk("arst_count", 32'(cnt), 32'd0);
    chk("arst_len_err", 32'(lerr), 32'd0);
    chk("arst_sel_q", 32'(selq), 32'd0);
    chk("arst_load_done", 32'(ld), 32'd0);
    m_sr = '0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_arst_count", 32'(cnt), 32'd0);
    chk("post_arst_cfgout", 32'(co), 32'd0);

    // over-length load, then a correct one clears the error
    sel = 1'b0;
    shift_bits(32'hABC, 12, 1'b0);
    do_load();
    shift_bits(32'h3C, 8, 1'b0);
    do_load();

    // counter saturates instead of wrapping
    shift_bits(32'h12345, 20, 1'b0);
    @(negedge clk);
    chk("count_saturated", 32'(cnt), 32'd15);
    do_load();

    // load edge coincides with the 8th clock edge
    shift_bits(32'hC3, 8, 1'b1);
    @(negedge clk);
    chk("coincident_count", 32'(cnt), 32'd0);

    // chip reset: edges ignored, everything held at zero
    sel = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    m_sr = '0; m_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      cclk  = ~cclk;
      cload = ~cload;
      repeat (2) @(posedge clk);
    end
    #1 cclk = 1'b0;
    cload = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("chiprst_count", 32'(cnt), 32'd0);
    chk("chiprst_parallel", 32'(po), 32'd0);
    chk("chiprst_cfgout", 32'(co), 32'd0);
    chk("chiprst_sel_q", 32'(selq), 32'd0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    shift_bits(32'h5A, 8, 1'b0);
    do_load();

    // loopback: eight ones appear on ConfigOut, then zeros
    shift_bits(32'hFF, 8, 1'b0);
    shift_bits(32'h00, 8, 1'b0);
    @(negedge clk);
    chk("loopback_drained", 32'(co), 32'd0);
    do_load();

    repeat (10) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/config_shift_reg_responder.md
Name: config_shift_reg_responder

Overview:
- Chip-side responder for the FPGA configuration shift-register interface (SuperpixSel, ConfigClk, Reset_not, ConfigIn, ConfigLoad, ConfigOut).
- Models the on-chip shift register and its load latch, and drives ConfigOut back to the FPGA. Used as the loopback target in simulation and in FPGA self-test builds.
- Samples all interface pins synchronously in the S_AXI_ACLK domain and shifts on detected ConfigClk rising edges. Also provides a parallel register image plus bit-count and length-error status.

Parameters:
- CONFIG_REG_WIDTH, 5164, shift/parallel register length in bits (minimum 2).
- CW, derived as $clog2(CONFIG_REG_WIDTH+1), width of the shift counter (localparam, not overridable).

Ports:
- S_AXI_ACLK  input  1  system clock; all logic is in this domain.
- S_AXI_ARESET  input  1  asynchronous, active-high reset.
- ConfigClk  input  1  config clock from the FPGA; asynchronous, synchronized internally.
- ConfigIn  input  1  serial data in.
- ConfigLoad  input  1  rising edge copies the shift register to ParallelOut.
- Reset_not  input  1  active-low chip reset from the FPGA.
- SuperpixSel  input  1  superpixel version select.
- ConfigOut  output  1  serial data out, equal to sr[CONFIG_REG_WIDTH-1].
- ParallelOut  output  CONFIG_REG_WIDTH  loaded configuration image.
- SuperpixSel_q  output  1  SuperpixSel value captured at the last load.
- load_done  output  1  one-cycle pulse per load.
- length_err  output  1  set when the last load saw a shift count other than CONFIG_REG_WIDTH.
- shift_count  output  CW  rising edges counted since the last load or reset; saturating.

Behaviour:
- Synchronizers: every input except S_AXI_ARESET passes through 2 flops (s1, s2), then a third flop (s3) for edge detect.
  - rise = s2 & ~s3.
  - ConfigIn, ConfigLoad, Reset_not and SuperpixSel use the same depth, so data stays aligned with clock edges.
- Async reset (S_AXI_ARESET=1) sets the following to 0: all sync flops, sr, ParallelOut, SuperpixSel_q, load_done, length_err, shift_count. It therefore also forces ConfigOut=0. Sync flops for Reset_not also reset to 0, so the block stays in chip-reset until Reset_not is seen high.
- Shift: on an ACLK edge with ConfigClk rise, sr <= {sr[W-2:0], ConfigIn_s2} and shift_count <= shift_count+1.
  - shift_count saturates at 2^CW-1; it does not wrap.
- Latency: if ConfigClk is first sampled high at ACLK edge k, sr and ConfigOut update at edge k+2.
- Input timing requirements:
  - ConfigClk high and low phases must each be ≥3 ACLK periods.
  - ConfigIn must be stable from 3 periods before to 1 period after the ConfigClk rising edge.
- Load: on an edge with ConfigLoad rise:
  - ParallelOut <= next sr value and SuperpixSel_q <= SuperpixSel_s2.
  - length_err <= (next shift_count != CONFIG_REG_WIDTH).
  - shift_count <= 0; load_done=1 for exactly one cycle.
- Simultaneous ConfigClk rise and ConfigLoad rise in the same cycle:
  - The shift applies first.
  - ParallelOut captures the post-shift value, and the length check includes that shift.
- Chip reset: while Reset_not_s2=0, sr, ParallelOut, shift_count and length_err are held at 0, and SuperpixSel_q is held at 0. ConfigClk and ConfigLoad edges are ignored and load_done stays 0.
  - Edge detect keeps running during chip reset, so an edge in progress at release does not fire spuriously. Only edges with s3 sampled after release count.
- ConfigOut is a direct flop output, with no combinational path from the inputs.
- ConfigLoad high level with no edge: no effect. Falling edges of ConfigClk and ConfigLoad: no effect.

Test Plan:
1. Async reset asserted mid-shift (W=8, after 3 edges) → all outputs are 0 immediately, without waiting for a clock edge. After release with Reset_not=1, shift_count starts at 0.
2. W=8: shift 0xA5 MSB-first with 10-cycle ConfigClk phases, then pulse ConfigLoad:
   - ParallelOut=0xA5, load_done is a single pulse, length_err=0, shift_count returns to 0.
   - ConfigOut shows the old sr MSB sequence, with each bit changing exactly 2 ACLK edges after the ConfigClk sample.
3. Shift 12 bits then load (W=8):
   - ParallelOut holds the last 8 bits and length_err=1.
   - A following correct 8-bit load clears length_err to 0.
4. ConfigLoad rise in the same ACLK cycle as the 8th ConfigClk rise → ParallelOut includes the 8th bit and length_err=0.
5. Reset_not=0 for 20 cycles while toggling ConfigClk and ConfigLoad → sr, ParallelOut and shift_count stay at 0 and there is no load_done. After Reset_not=1, a new 8-bit shift and load works normally.
6. Loopback: shift 0xFF, then 8 zeros → ConfigOut outputs eight 1s in order, then sr=0 and ConfigOut=0.
